vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL declare parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL declare parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal porch and sync widths, in pixels.
REQ-003 SHALL declare parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL declare parameters V_FP 10, V_SYNC 2, V_BP 33: vertical porch and sync widths, in lines.
REQ-005 SHALL declare parameter FB_WIDTH, default 320: framebuffer row pitch in pixels; the framebuffer is 320x240 with 2x pixel/line replication.
REQ-006 SHALL have port clock, input, 1 bit: 50 MHz system clock, the only clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port mem_addr, output, 17 bits: framebuffer read address.
REQ-009 SHALL have port mem_rd, output, 1 bit: read strobe.
REQ-010 SHALL have port mem_data, input, 3 bits: {R,G,B} pixel, valid exactly 1 clock after mem_rd.
REQ-011 SHALL have ports VGA_R, VGA_G, VGA_B, outputs, 8 bits each: DAC channels.
REQ-012 SHALL have ports VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, outputs, 1 bit each.
REQ-013 SHALL have port frame_start, output, 1 bit: one-clock pulse at the start of each frame.

Function
REQ-014 SHALL generate a pixel enable pix_en that toggles every clock (25 MHz).
REQ-015 SHALL drive VGA_CLK from a register equal to pix_en, giving a 50% duty cycle.
REQ-016 SHALL advance hcount (0..799) only on pix_en cycles; wrapping 799->0 SHALL advance vcount (0..524), which wraps 524->0.
REQ-017 Pipeline stage A, on a pix_en edge, SHALL register mem_addr = (vcount>>1)*FB_WIDTH + (hcount>>1).
REQ-018 Stage A SHALL assert mem_rd for one clock only when hcount<H_ACTIVE and vcount<V_ACTIVE; otherwise mem_rd=0 and mem_addr holds its value.
REQ-019 Stage B, on the next pix_en edge, SHALL register each channel = {8{mem_data bit}} (R=bit2, G=bit1, B=bit0), or 0 when the delayed blank is active.
REQ-020 Sync and blank SHALL be computed from the counters and delayed 2 pixel slots so that they align with RGB.
REQ-021 VGA_HS SHALL be low for hcount in 656..751.
REQ-022 VGA_VS SHALL be low for vcount in 490..491.
REQ-023 VGA_BLANK_N SHALL be high only in the active region.
REQ-024 VGA_SYNC_N SHALL be constant 0.
REQ-025 Address arithmetic SHALL be unsigned, 17 bits, with no overflow; the maximum is 76799.
REQ-026 frame_start SHALL pulse for one clock on the pix_en edge where hcount and vcount both wrap to 0.
REQ-027 mem_data SHALL be sampled only on pix_en edges; its value in other clocks is don't-care.

Reset
REQ-028 While reset is asserted, all state SHALL clear on the clock edge: pix_en=0, hcount=0, vcount=0, VGA_CLK=0, pipeline valid bits=0.
REQ-029 While reset is asserted, outputs SHALL be: mem_addr=0, mem_rd=0, RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_start=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame within 1 clock; after release, scanout SHALL restart at (0,0) with no frame_start pulse for the aborted frame.
REQ-031 The first frame_start SHALL occur on the first counter wrap after reset release.

Structure
REQ-032 Timing constants and the colour-expansion rule SHALL reside in the shared package vga_pkg.
REQ-033 The block SHALL contain one sub-module, vga_timing_counter, producing hcount, vcount, hs_raw, vs_raw, active and wrap.
REQ-034 The block SHALL contain no memory; the framebuffer is external.

Verification
REQ-035 Reset held 5 clocks then released -> outputs at reset values; VGA_CLK toggles starting on the 1st clock after release.
REQ-036 Run one full line -> VGA_HS low for exactly 192 clocks, beginning 2 pixel slots after hcount reaches 656.
REQ-037 Run a frame with a memory model returning addr[2:0] -> addresses at (h0,v0)=0, (h2,v0)=1, (h0,v2)=320, (h639,v479)=76799; mem_rd=0 in the blanking region.
REQ-038 mem_data=3'b101 at pixel (0,0) -> VGA_R=FF, VGA_G=00, VGA_B=FF, VGA_BLANK_N=1 exactly 2 pixel slots later.
REQ-039 Free run -> frame_start period = 840000 clocks; VGA_VS low for 2 lines (3200 clocks).
REQ-040 Reset asserted at (h300,v200) -> the next clock shows reset values, and the next frame_start arrives 840000 clocks after release.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, counter/address widths, pipeline depth,
// sync/colour types, framebuffer address helper and the 3-bit -> 24-bit
// colour-expansion rule used by vga_scanout.
package vga_pkg;

  // 640x480@60 raster, in pixels / lines
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int FB_WIDTH_DEF = 320;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 17;
  // pixel slots between counter sample and RGB output (address, then data)
  localparam int STAGES = 2;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // {R,G,B} bit -> full-scale channel
  function automatic rgb_t expand_rgb(input logic [2:0] px);
    rgb_t c;
    c.r = {8{px[2]}};
    c.g = {8{px[1]}};
    c.b = {8{px[0]}};
    return c;
  endfunction

  // 2x pixel/line replication: screen (h,v) -> framebuffer (h/2, v/2)
  function automatic addr_t fb_addr(input cnt_t h, input cnt_t v, input addr_t pitch);
    addr_t row;
    addr_t col;
    row = ADDR_W'(v >> 1);
    col = ADDR_W'(h >> 1);
    return row * pitch + col;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: raster position counters advanced on pix_en.
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   pix_en         - pixel-rate enable
//   hcount, vcount - current raster position
//   hs_raw, vs_raw - undelayed active-low syncs
//   active         - position is inside the visible area
//   wrap           - this pix_en cycle wraps both counters to (0,0)
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic pix_en,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic hs_raw,
  output logic vs_raw,
  output logic active,
  output logic wrap
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;

  logic h_last, v_last;

  assign h_last = (hcount == cnt_t'(H_TOTAL - 1));
  assign v_last = (vcount == cnt_t'(V_TOTAL - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + cnt_t'(1);
      end else begin
        hcount <= hcount + cnt_t'(1);
      end
    end
  end

  assign wrap   = pix_en & h_last & v_last;
  assign hs_raw = !(hcount >= cnt_t'(H_SYNC_LO) && hcount < cnt_t'(H_SYNC_HI));
  assign vs_raw = !(vcount >= cnt_t'(V_SYNC_LO) && vcount < cnt_t'(V_SYNC_HI));
  assign active = (hcount < cnt_t'(H_ACTIVE)) && (vcount < cnt_t'(V_ACTIVE));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: reads a 320x240 3-bit framebuffer and drives a VGA DAC at
// 640x480 with 2x pixel/line replication. One pixel slot = 2 clocks.
// Ports:
//   clock, reset            - 50 MHz clock, synchronous active-high reset
//   mem_addr, mem_rd        - framebuffer read request (data 1 clock later)
//   mem_data                - {R,G,B} pixel
//   VGA_R/G/B               - 8-bit DAC channels
//   VGA_HS/VS/BLANK_N/SYNC_N/CLK - DAC control and syncs
//   frame_start             - one-clock pulse when the raster wraps to (0,0)
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int FB_WIDTH = FB_WIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [2:0]        mem_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic              VGA_CLK,
  output logic              frame_start
);

  logic  pix_en;
  cnt_t  hcount, vcount;
  logic  hs_raw, vs_raw, active, wrap;

  // [0]: counters valid, [1]: stage A (address) valid, [2]: stage B (RGB) valid
  logic [STAGES:0] vld_pipe;
  sync_t sync_a, sync_b;
  rgb_t  rgb_q;
  addr_t addr_q;
  logic  rd_q;
  logic  fs_q;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tc (
    .clock  (clock),
    .reset  (reset),
    .pix_en (pix_en),
    .hcount (hcount),
    .vcount (vcount),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .active (active),
    .wrap   (wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en   <= 1'b0;
      vld_pipe <= '0;
      sync_a   <= SYNC_IDLE;
      sync_b   <= SYNC_IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      rgb_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      vld_pipe[0] <= 1'b1;
      rd_q        <= 1'b0;       // strobe lasts a single clock
      fs_q        <= wrap;       // wrap already qualified by pix_en
      if (pix_en) begin
        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        // stage A: address + undelayed sync sample
        sync_a <= '{hs: hs_raw, vs: vs_raw, active: active};
        if (active) begin
          addr_q <= fb_addr(hcount, vcount, ADDR_W'(FB_WIDTH));
          rd_q   <= 1'b1;
        end
        // stage B: mem_data arrived in the intervening non-enable clock
        sync_b <= sync_a;
        rgb_q  <= (vld_pipe[1] && sync_a.active) ? expand_rgb(mem_data) : '0;
      end
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;
  assign VGA_HS      = vld_pipe[STAGES] ? sync_b.hs : 1'b1;
  assign VGA_VS      = vld_pipe[STAGES] ? sync_b.vs : 1'b1;
  assign VGA_BLANK_N = vld_pipe[STAGES] & sync_b.active;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of vga_scanout. u_full uses the default
// 640x480 raster for line-level timing and early addresses; u_small uses a
// 16x10 total raster (8x6 visible, 4-pixel pitch) so frame-level behaviour
// completes in a few hundred clocks.
module tb_vga_scanout;

  logic clock = 1'b0;
  always #10 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int k        = 0;   // posedges since the current DUT left reset

  // full-size instance
  logic        reset_f;
  logic [16:0] mem_addr_f;
  logic        mem_rd_f;
  logic [2:0]  mem_data_f = 3'b000;
  logic [7:0]  r_f, g_f, b_f;
  logic        hs_f, vs_f, blank_n_f, sync_n_f, vclk_f, fs_f;

  // reduced-raster instance
  logic        reset_s;
  logic [16:0] mem_addr_s;
  logic        mem_rd_s;
  logic [2:0]  mem_data_s = 3'b000;
  logic [7:0]  r_s, g_s, b_s;
  logic        hs_s, vs_s, blank_n_s, sync_n_s, vclk_s, fs_s;

  vga_scanout u_full (
    .clock(clock), .reset(reset_f),
    .mem_addr(mem_addr_f), .mem_rd(mem_rd_f), .mem_data(mem_data_f),
    .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f),
    .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(blank_n_f),
    .VGA_SYNC_N(sync_n_f), .VGA_CLK(vclk_f), .frame_start(fs_f)
  );

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FB_WIDTH(4)
  ) u_small (
    .clock(clock), .reset(reset_s),
    .mem_addr(mem_addr_s), .mem_rd(mem_rd_s), .mem_data(mem_data_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
    .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_n_s),
    .VGA_SYNC_N(sync_n_s), .VGA_CLK(vclk_s), .frame_start(fs_s)
  );

  // Memory models: data = addr[2:0] ^ 3'b101, one clock after mem_rd
  // (address 0 therefore returns 3'b101).
  always @(posedge clock) begin
    mem_data_f <= mem_rd_f ? (mem_addr_f[2:0] ^ 3'b101) : 3'b000;
    mem_data_s <= mem_rd_s ? (mem_addr_s[2:0] ^ 3'b101) : 3'b000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (k < target) begin
      @(negedge clock);
      k++;
    end
  endtask

  initial begin
    int cnt;
    reset_f = 1'b1;
    reset_s = 1'b1;

    // ---------------- full raster ----------------
    repeat (5) @(negedge clock);
    chk("rst_vclk",   {31'd0, vclk_f},    32'd0);
    chk("rst_addr",   {15'd0, mem_addr_f}, 32'd0);
    chk("rst_rd",     {31'd0, mem_rd_f},  32'd0);
    chk("rst_rgb",    {8'd0, r_f, g_f, b_f}, 32'd0);
    chk("rst_hs",     {31'd0, hs_f},      32'd1);
    chk("rst_vs",     {31'd0, vs_f},      32'd1);
    chk("rst_blank",  {31'd0, blank_n_f}, 32'd0);
    chk("rst_sync_n", {31'd0, sync_n_f},  32'd0);
    chk("rst_fs",     {31'd0, fs_f},      32'd0);

    reset_f = 1'b0;
    k = 0;
    step_to(1);
    chk("vclk_1", {31'd0, vclk_f}, 32'd1);
    step_to(2);
    chk("vclk_2",  {31'd0, vclk_f},     32'd0);
    chk("addr_h0", {15'd0, mem_addr_f}, 32'd0);
    chk("rd_h0",   {31'd0, mem_rd_f},   32'd1);
    step_to(3);
    chk("rd_pulse",   {31'd0, mem_rd_f},  32'd0);
    chk("blank_early",{31'd0, blank_n_f}, 32'd0);
    step_to(4);
    chk("rgb_h0",   {8'd0, r_f, g_f, b_f}, 32'h00FF00FF);
    chk("blank_h0", {31'd0, blank_n_f},    32'd1);
    step_to(6);
    chk("addr_h2", {15'd0, mem_addr_f}, 32'd1);
    step_to(8);
    chk("rgb_h2", {8'd0, r_f, g_f, b_f}, 32'h00FF0000);
    step_to(1280);
    chk("addr_h639", {15'd0, mem_addr_f}, 32'd319);
    chk("rd_h639",   {31'd0, mem_rd_f},   32'd1);
    step_to(1282);
    chk("rd_hblank",   {31'd0, mem_rd_f},     32'd0);
    chk("addr_hold",   {15'd0, mem_addr_f},   32'd319);
    chk("rgb_h639",    {8'd0, r_f, g_f, b_f}, 32'h0000FF00);
    chk("blank_h639",  {31'd0, blank_n_f},    32'd1);
    step_to(1284);
    chk("blank_h640", {31'd0, blank_n_f},    32'd0);
    chk("rgb_h640",   {8'd0, r_f, g_f, b_f}, 32'd0);
    step_to(1315);
    chk("hs_before", {31'd0, hs_f}, 32'd1);
    step_to(1316);
    chk("hs_fall", {31'd0, hs_f}, 32'd0);
    cnt = 0;
    while (hs_f == 1'b0 && cnt < 400) begin
      @(negedge clock);
      k++;
      cnt++;
    end
    chk("hs_low_len", cnt, 32'd192);
    step_to(3202);
    chk("addr_v2", {15'd0, mem_addr_f}, 32'd320);
    chk("rd_v2",   {31'd0, mem_rd_f},   32'd1);

    // ---------------- reduced raster ----------------
    reset_s = 1'b0;
    k = 0;
    step_to(1);
    chk("s_vclk_1", {31'd0, vclk_s}, 32'd1);
    step_to(176);
    chk("s_addr_last", {15'd0, mem_addr_s}, 32'd11);
    chk("s_rd_last",   {31'd0, mem_rd_s},   32'd1);
    step_to(194);
    chk("s_rd_vblank", {31'd0, mem_rd_s}, 32'd0);
    step_to(227);
    chk("s_vs_before", {31'd0, vs_s}, 32'd1);
    step_to(228);
    chk("s_vs_fall", {31'd0, vs_s}, 32'd0);
    cnt = 0;
    while (vs_s == 1'b0 && cnt < 400) begin
      @(negedge clock);
      k++;
      cnt++;
    end
    chk("s_vs_low_len", cnt, 32'd64);
    step_to(319);
    chk("s_fs_pre", {31'd0, fs_s}, 32'd0);
    step_to(320);
    chk("s_fs_first", {31'd0, fs_s}, 32'd1);
    cnt = 0;
    do begin
      @(negedge clock);
      k++;
      cnt++;
    end while (fs_s == 1'b0 && cnt < 1000);
    chk("s_fs_period", cnt, 32'd320);
    step_to(641);
    chk("s_fs_one_clk", {31'd0, fs_s}, 32'd0);

    // mid-frame reset at raster (5,3); stage A holds pixel (4,3)
    step_to(746);
    chk("s_addr_mid", {15'd0, mem_addr_s}, 32'd6);
    chk("s_rd_mid",   {31'd0, mem_rd_s},   32'd1);
    reset_s = 1'b1;
    step_to(747);
    chk("s_rst_addr",  {15'd0, mem_addr_s},   32'd0);
    chk("s_rst_rd",    {31'd0, mem_rd_s},     32'd0);
    chk("s_rst_rgb",   {8'd0, r_s, g_s, b_s}, 32'd0);
    chk("s_rst_hs",    {31'd0, hs_s},         32'd1);
    chk("s_rst_vs",    {31'd0, vs_s},         32'd1);
    chk("s_rst_blank", {31'd0, blank_n_s},    32'd0);
    chk("s_rst_fs",    {31'd0, fs_s},         32'd0);
    chk("s_rst_vclk",  {31'd0, vclk_s},       32'd0);
    step_to(749);
    reset_s = 1'b0;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (fs_s == 1'b0 && cnt < 1000);
    chk("s_fs_after_rst", cnt, 32'd320);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
